// File: rtl/range_arbiter.sv
// range_arbiter: round-robin session arbiter in front of one shared
// range-finder datapath. A granted requester streams samples; the arbiter
// forwards them to the datapath on registered go/finish/data pins. It then
// captures the computed range and returns it with a one-cycle done pulse.
//
// Optional build macro RANGE_ARB_TIMEOUT_EN adds an idle-sample watchdog.
// The watchdog aborts a session after TIMEOUT_CYCLES RUN cycles without an
// accepted sample and pulses timeout together with done. Without the macro
// RUN waits indefinitely for the final sample and timeout is tied to 0.
module range_arbiter #(
    parameter int WIDTH          = 16,
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           result,
    output logic                       busy,
    output logic                       timeout,
    output logic                       protocol_err,
    output logic [WIDTH-1:0]           rf_data,
    output logic                       rf_go,
    output logic                       rf_finish,
    input  logic [WIDTH-1:0]           rf_range,
    input  logic                       rf_error
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIN,
        ST_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [IDX_W-1:0]     grant_idx_reg, grant_idx_next;
    logic [IDX_W-1:0]     ptr_reg, ptr_next;
    logic [WIDTH-1:0]     rf_data_reg, rf_data_next;
    logic                 rf_go_reg, rf_go_next;
    logic                 rf_finish_reg, rf_finish_next;
    logic [WIDTH-1:0]     result_reg, result_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic                 go_issued_reg, go_issued_next;
    logic                 last_pending_reg, last_pending_next;
    logic                 protocol_err_reg;

    logic [WIDTH-1:0]     sample_arr [NUM_REQ];
    logic [NUM_REQ-1:0]   take_vec;
    logic [NUM_REQ-1:0]   take_last_vec;
    logic [WIDTH-1:0]     sample_sel;
    logic                 run_open;
    logic                 take_any;
    logic                 take_last;
    logic                 to_hit;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W:0]       cand;

    // Per-requester sample slices and grant-qualified accept strobes; only
    // the owner's valid/last can ever reach the datapath.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign sample_arr[gi]    = req_data[gi*WIDTH +: WIDTH];
            assign take_vec[gi]      = grant_reg[gi] & req_valid[gi];
            assign take_last_vec[gi] = grant_reg[gi] & req_valid[gi] & req_last[gi];
        end
    endgenerate

    // Samples are accepted only in RUN and only until the final one is seen.
    assign run_open  = (state_reg == ST_RUN) && !last_pending_reg;
    assign take_any  = run_open && (|take_vec);
    assign take_last = run_open && (|take_last_vec);

    // One-hot AND-OR mux of the owner's sample.
    always_comb begin
        sample_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_reg[k]) begin
                sample_sel = sample_sel | sample_arr[k];
            end
        end
    end

    // Round-robin pick: first requesting index at or above the pointer,
    // wrapping. Scanning from the far end lets the nearest candidate win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_reg;
    logic            timed_out_reg;
    logic            timeout_reg;

    assign to_hit  = run_open && !take_any && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES));
    assign timeout = timeout_reg;

    // Watchdog: restarts on RUN entry and on every accepted sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_reg <= '0;
        end else if (state_reg != ST_RUN || take_any) begin
            to_cnt_reg <= '0;
        end else if (!last_pending_reg && !to_hit) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    // Remember an aborted session so timeout pulses alongside done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timed_out_reg <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE) begin
                timed_out_reg <= 1'b0;
            end else if (to_hit) begin
                timed_out_reg <= 1'b1;
            end
            timeout_reg <= (state_reg == ST_FIN) && timed_out_reg;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Session FSM next-state and registered-output next values.
    always_comb begin
        state_next        = state_reg;
        grant_next        = grant_reg;
        grant_idx_next    = grant_idx_reg;
        ptr_next          = ptr_reg;
        rf_data_next      = rf_data_reg;
        rf_go_next        = 1'b0;
        rf_finish_next    = 1'b0;
        result_next       = result_reg;
        done_next         = '0;
        go_issued_next    = go_issued_reg;
        last_pending_next = last_pending_reg;

        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_next        = NUM_REQ'(1) << pick_idx;
                    grant_idx_next    = pick_idx;
                    go_issued_next    = 1'b0;
                    last_pending_next = 1'b0;
                    state_next        = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_pending_reg) begin
                    // Last sample reached the datapath last cycle; close now.
                    rf_finish_next = 1'b1;
                    state_next     = ST_FIN;
                end else if (take_any) begin
                    rf_data_next   = sample_sel;
                    rf_go_next     = !go_issued_reg;
                    go_issued_next = 1'b1;
                    if (take_last) begin
                        last_pending_next = 1'b1;
                    end
                end else if (to_hit) begin
                    // Finish only a session the datapath has actually started.
                    rf_finish_next = go_issued_reg;
                    state_next     = ST_FIN;
                end
            end
            ST_FIN: begin
                result_next = rf_finish_reg ? rf_range : '0;
                done_next   = grant_reg;
                grant_next  = '0;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                ptr_next   = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                                   : grant_idx_reg + IDX_W'(1);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any session silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            grant_reg        <= '0;
            grant_idx_reg    <= '0;
            ptr_reg          <= '0;
            rf_data_reg      <= '0;
            rf_go_reg        <= 1'b0;
            rf_finish_reg    <= 1'b0;
            result_reg       <= '0;
            done_reg         <= '0;
            go_issued_reg    <= 1'b0;
            last_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            grant_reg        <= grant_next;
            grant_idx_reg    <= grant_idx_next;
            ptr_reg          <= ptr_next;
            rf_data_reg      <= rf_data_next;
            rf_go_reg        <= rf_go_next;
            rf_finish_reg    <= rf_finish_next;
            result_reg       <= result_next;
            done_reg         <= done_next;
            go_issued_reg    <= go_issued_next;
            last_pending_reg <= last_pending_next;
        end
    end

    // Sticky datapath misuse flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            protocol_err_reg <= 1'b0;
        end else if (rf_error) begin
            protocol_err_reg <= 1'b1;
        end
    end

    assign grant        = grant_reg;
    assign done         = done_reg;
    assign result       = result_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign protocol_err = protocol_err_reg;
    assign rf_data      = rf_data_reg;
    assign rf_go        = rf_go_reg;
    assign rf_finish    = rf_finish_reg;

endmodule

// File: tb/tb_range_arbiter.sv
// tb_range_arbiter: directed bench for range_arbiter with a behavioural
// min/max range-finder on the rf_* pins. Expected results are hand-computed.
module tb_range_arbiter;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 8;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_data = '0;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     grant;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic             busy;
    logic             timeout;
    logic             protocol_err;
    logic [W-1:0]     rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [W-1:0]     rf_range;
    logic             rf_error;
    logic             err_force = 1'b0;

    range_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
        .req_valid(req_valid), .req_last(req_last), .grant(grant), .done(done),
        .result(result), .busy(busy), .timeout(timeout), .protocol_err(protocol_err),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error)
    );

    always #5 clock = ~clock;

    // Behavioural range-finder: tracks min/max from rf_go until rf_finish.
    logic [W-1:0] m_min, m_max;
    logic         m_active;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_min    <= '0;
            m_max    <= '0;
        end else if (rf_go) begin
            m_active <= 1'b1;
            m_min    <= rf_data;
            m_max    <= rf_data;
        end else if (rf_finish) begin
            m_active <= 1'b0;
        end else if (m_active) begin
            if (rf_data < m_min) m_min <= rf_data;
            if (rf_data > m_max) m_max <= rf_data;
        end
    end
    assign rf_range = m_max - m_min;
    assign rf_error = err_force | (rf_finish & ~m_active);

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor, sampled on the falling edge.
    int           go_cnt = 0, fin_cnt = 0, done_cnt = 0;
    int           fin_cyc = 0, done_cyc = 0;
    logic [W-1:0] go_val = '0, done_res = '0;
    logic [N-1:0] done_vec = '0, done_grant = '0;
    logic         done_to = 1'b0;
    always @(negedge clock) begin
        if (rf_go) begin
            go_cnt = go_cnt + 1;
            go_val = rf_data;
        end
        if (rf_finish) begin
            fin_cnt = fin_cnt + 1;
            fin_cyc = cyc;
        end
        if (|done) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            done_vec   = done;
            done_res   = result;
            done_grant = grant;
            done_to    = timeout;
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    int smp[$];
    logic noise_on = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full session on requester idx using samples in smp.
    task automatic run_sess(input int idx, input int gap, input int exp_res, input logic drop);
        int b_go, b_fin, b_done, last_acc, waited;
        b_go   = go_cnt;
        b_fin  = fin_cnt;
        b_done = done_cnt;
        last_acc = 0;
        req[idx] = 1'b1;
        waited = 0;
        while (!(|grant) && waited < 20) begin
            tick();
            waited++;
        end
        chk("grant_onehot", int'(grant), 1 << idx);
        if (noise_on) begin
            req[1]            = 1'b1;
            req_valid[1]      = 1'b1;
            req_last[1]       = 1'b1;
            req_data[W +: W]  = W'(100);
        end
        if (drop) req[idx] = 1'b0;
        for (int i = 0; i < smp.size(); i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("rf_data_held", int'(rf_data), smp[i-1]);
                end
            end
            if (noise_on && i == 1) req_data[W +: W] = W'(1);
            req_valid[idx]          = 1'b1;
            req_data[idx*W +: W]    = W'(smp[i]);
            req_last[idx]           = (i == smp.size() - 1);
            tick();
            last_acc       = cyc;
            req_valid[idx] = 1'b0;
            req_last[idx]  = 1'b0;
            chk("rf_data", int'(rf_data), smp[i]);
            if (i == 0) chk("rf_go_first", int'(rf_go), 1);
        end
        repeat (3) tick();
        chk("go_count", go_cnt - b_go, 1);
        chk("go_value", int'(go_val), smp[0]);
        chk("fin_count", fin_cnt - b_fin, 1);
        chk("fin_latency", fin_cyc - last_acc, 1);
        chk("done_count", done_cnt - b_done, 1);
        chk("done_latency", done_cyc - last_acc, 2);
        chk("done_vec", int'(done_vec), 1 << idx);
        chk("done_result", int'(done_res), exp_res);
        chk("grant_at_done", int'(done_grant), 0);
        chk("busy_after", int'(busy), 0);
        if (noise_on) begin
            req[1]       = 1'b0;
            req_valid[1] = 1'b0;
            req_last[1]  = 1'b0;
        end
        $display("session req=%0d samples=%0d result=%0d", idx, smp.size(), result);
    endtask

    initial begin
        int b_done, b_fin, acc, waited;

        // Reset state
        repeat (3) tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_rf_data", int'(rf_data), 0);
        chk("rst_rf_go", int'(rf_go), 0);
        chk("rst_rf_finish", int'(rf_finish), 0);
        chk("rst_perr", int'(protocol_err), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset_n = 1'b1;
        tick();

        // All requesters held: one-sample sessions rotate 0,1,2,3,0
        req = '1;
        smp = '{3};
        run_sess(0, 0, 0, 1'b0);
        run_sess(1, 0, 0, 1'b0);
        run_sess(2, 0, 0, 1'b0);
        run_sess(3, 0, 0, 1'b0);
        run_sess(0, 0, 0, 1'b0);
        req = '0;
        chk("perr_clean", int'(protocol_err), 0);

        // Single requester, 5 9 2 7, req dropped mid-session: range 7
        smp = '{5, 9, 2, 7};
        run_sess(0, 0, 7, 1'b1);

        // Requester 1 noise ignored while 0 owns the session: range 10
        noise_on = 1'b1;
        smp = '{10, 20};
        run_sess(0, 0, 10, 1'b0);
        noise_on = 1'b0;
        req[0] = 1'b0;

        // Idle gaps of 5 cycles between 50 40 60: range 20
        smp = '{50, 40, 60};
        run_sess(2, 5, 20, 1'b1);

        // rf_error makes protocol_err sticky
        err_force = 1'b1;
        tick();
        err_force = 1'b0;
        tick();
        tick();
        chk("perr_sticky", int'(protocol_err), 1);

        // Reset mid-RUN on requester 3 (pointer is 3 at this point)
        req[3] = 1'b1;
        waited = 0;
        while (!(|grant) && waited < 20) begin
            tick();
            waited++;
        end
        chk("r5_grant", int'(grant), 8);
        req_valid[3]       = 1'b1;
        req_data[3*W +: W] = W'(77);
        tick();
        req_valid[3] = 1'b0;
        req[3]       = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", int'(grant), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_rf_data", int'(rf_data), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_perr", int'(protocol_err), 0);
        chk("mid_rst_done", int'(done), 0);
        tick();
        tick();
        #2 reset_n = 1'b1;
        tick();
        // Pointer restarted at 0: with 2 and 3 requesting, 2 wins
        req[3] = 1'b1;
        smp = '{11, 15};
        run_sess(2, 0, 4, 1'b1);
        req[3] = 1'b0;
        tick();
        chk("post_rst_idle", int'(busy), 0);

        // One sample 30 then silence
        req[0] = 1'b1;
        waited = 0;
        while (!(|grant) && waited < 20) begin
            tick();
            waited++;
        end
        chk("to_grant", int'(grant), 1);
        b_done = done_cnt;
        b_fin  = fin_cnt;
        req_valid[0]   = 1'b1;
        req_data[0 +: W] = W'(30);
        tick();
        acc = cyc;
        req_valid[0] = 1'b0;
        req[0]       = 1'b0;
        waited = 0;
        while (done_cnt == b_done && waited < 40) begin
            tick();
            waited++;
        end
`ifdef RANGE_ARB_TIMEOUT_EN
        chk("to_done_count", done_cnt - b_done, 1);
        chk("to_done_vec", int'(done_vec), 1);
        chk("to_pulse", int'(done_to), 1);
        chk("to_result", int'(done_res), 0);
        chk("to_fin_count", fin_cnt - b_fin, 1);
        chk("to_latency", done_cyc - acc, TO + 2);
        tick();
        chk("to_pulse_end", int'(timeout), 0);
`else
        chk("no_to_done", done_cnt - b_done, 0);
        chk("no_to_busy", int'(busy), 1);
        chk("no_to_timeout", int'(timeout), 0);
        chk("no_to_fin", fin_cnt - b_fin, 0);
        if (acc < 0) chk("acc_cycle", acc, 0);
`endif
        $display("session req=0 samples=1 timeout=%0d result=%0d", done_to, result);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/range_arbiter.md
Name: range_arbiter

Overview:
- Shares one range-finder datapath among NUM_REQ sample-stream requesters.
- Grants sessions in round-robin order and drives the datapath's go/finish/data pins.
- Captures the computed range and returns it to the granted requester with a done pulse.
- Sits between the sample producers and the single range-finder instance. The datapath's active-high reset is driven from ~reset_n at integration.

Parameters:
- WIDTH, 16, sample and range width in bits.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, idle-sample watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  requester i wants a session.
- req_data  in  NUM_REQ*WIDTH  packed samples; slice i = req_data[i*WIDTH +: WIDTH].
- req_valid  in  NUM_REQ  sample valid per requester.
- req_last  in  NUM_REQ  qualifies a valid sample as the final one of the session.
- grant  out  NUM_REQ  one-hot session owner; doubles as ready.
- done  out  NUM_REQ  one-cycle pulse to the owner when result is valid.
- result  out  WIDTH  range of the most recent session; held until the next done.
- busy  out  1  high in any state other than IDLE.
- timeout  out  1  one-cycle pulse with done when a session was aborted; constant 0 without the macro.
- protocol_err  out  1  sticky; set when rf_error is seen high.
- rf_data  out  WIDTH  sample to the datapath (registered).
- rf_go  out  1  session start to the datapath (registered).
- rf_finish  out  1  session end to the datapath (registered).
- rf_range  in  WIDTH  datapath range; valid while rf_finish is high.
- rf_error  in  1  datapath misuse flag.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0, state IDLE, round-robin pointer 0, protocol_err cleared. Reset mid-session abandons the session with no done pulse.
- States: IDLE, RUN, FIN, DONE.
- IDLE:
  - If any req bit is high, select the first set bit at or above the pointer, wrapping.
  - Set grant to that one-hot value and go to RUN; grant is visible the cycle after req is sampled.
  - With no req, stay in IDLE.
- RUN:
  - A sample is accepted in cycle t when grant[i] & req_valid[i]. rf_data = that sample at t+1.
  - The first accepted sample of the session also sets rf_go=1 at t+1, for one cycle only.
  - rf_data holds its last value between samples. The datapath compares every cycle, so a repeated held sample cannot change the extremes; do not zero it.
  - req, req_valid and req_last of non-granted requesters are ignored.
  - Deasserting req mid-session is ignored; the session runs to last (or timeout).
  - Accepted sample with req_last=1: go to FIN. No further samples are accepted from that cycle on.
- FIN (t+2 relative to the last sample accepted at t): rf_finish=1 for exactly one cycle. Register rf_range into result at the end of that cycle.
- DONE (t+3):
  - done[i]=1, grant=0, result valid.
  - Pointer becomes i+1 mod NUM_REQ.
  - Next state is IDLE.
- Single-sample session: go at t+1, finish at t+2, result 0.
- Fairness: a requester just served has lowest priority in the next arbitration.
- rf_finish is never asserted without a prior rf_go in the same session. Any rf_error sets protocol_err until reset.
- No arithmetic on data: result is a straight copy of rf_range, width WIDTH.

Optional Feature:
- Macro: RANGE_ARB_TIMEOUT_EN.
- When defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) clears on each accepted sample and on entry to RUN, and increments each RUN cycle without one.
  - On reaching TIMEOUT_CYCLES, go to FIN:
    - If rf_go was issued, run the normal finish and capture.
    - If no sample was ever accepted, skip rf_finish and set result=0.
  - In DONE, pulse timeout together with done.
- When undefined: no counter logic; RUN waits indefinitely; timeout tied 0.

Test Plan:
- Single requester: req[0], samples 5,9,2,7 (last on 7) -> rf_go with 5, rf_finish 2 cycles after 7 is accepted, result=7, done[0] one cycle later, busy returns 0.
- req=4'b1111 held, each session with one sample 3 and last -> grants in order 0,1,2,3,0; result=0 each; no protocol_err.
- Requester 1 drives valid samples 100 and 1 while grant[0] holds a session with samples 10,20 -> requester 1's samples ignored; result=10.
- Gaps of 5 idle cycles between samples 50, 40, 60 -> rf_data held constant during gaps; result=20.
- reset_n pulled low mid-RUN -> all outputs 0 immediately; after release, a new session on req[2] completes normally with pointer restarted at 0.
- With RANGE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: one sample 30 then silence -> done and timeout pulse together, result=0. Without the macro, the same stimulus leaves busy=1 indefinitely.
